fifo_read_ctrl: RTL and testbench
=================================

// Module: fifo_read_ctrl
// PURPOSE
//  Read-side controller for the FIFO's dual-port RAM (ram_dual). Compares the writer's pointer against its own,
//  issues RAM read addresses, absorbs the RAM's 1-cycle registered-address read latency, and presents the data
//  as a show-ahead valid/ready stream. Returns a release pointer to the write-side controller for full detection.
// PARAMETERS
//  ADDRESS_WIDTH  13  RAM address bits; depth = 2**ADDRESS_WIDTH; pointers are ADDRESS_WIDTH+1 bits (wrap bit)
//  DATA_WIDTH     32  word width; must match the RAM
// PORTS
//  fiford_clk_i        in   1      single clock, also drives the RAM
//  fiford_rstn_i       in   1      asynchronous, active-low reset
//  fiford_wrptr_i      in   AW+1   writer's pointer (next slot to write), same clock domain
//  fiford_flush_i      in   1      synchronous discard of all unread entries
//  fiford_ramaddr_o    out  AW     to dualram_read_addr_i
//  fiford_ramdata_i    in   DW     from dualram_readdata_o
//  fiford_relptr_o     out  AW+1   release pointer to writer; slots below it may be overwritten
//  fiford_data_o       out  DW     stream data, head of output buffer
//  fiford_valid_o      out  1      stream data valid
//  fiford_ready_i      in   1      consumer ready
//  fiford_level_o      out  AW+1   entries written but not yet popped
// BEHAVIOUR
//  Reset (async, rstn=0): fetch ptr, relptr, pop ptr, inflight, buffer count := 0; valid_o=0, data_o=0,
//   ramaddr_o=0, relptr_o=0, level_o follows wrptr_i - 0.
//  avail = (wrptr_i != fetch_ptr). occ = buf_count + inflight (0..2). pop = valid_o & ready_i.
//  fetch = avail & ((occ - pop) < 2) & ~flush_i. ramaddr_o = fetch_ptr[AW-1:0] (combinational).
//  Fetch in cycle t: fetch_ptr += 1 and inflight := 1 at edge ending t; RAM data valid during t+1;
//   captured into output buffer at edge ending t+1 (inflight clears unless a new fetch occurred in t+1).
//  relptr_o increments at each capture edge, never earlier: a slot is released only after its data is held
//   in the buffer, so a same-edge overwrite cannot corrupt it.
//  Output buffer: 2-entry FIFO; valid_o = (buf_count != 0); data_o = head. Once valid_o is high, data_o
//   holds stable until pop. Simultaneous capture and pop: count unchanged, head advances.
//  Latency: wrptr_i advances in cycle t (FIFO empty) -> fetch in t -> valid_o high in t+2.
//  Throughput: 1 word/cycle sustained while ready_i=1 and avail=1; no bubbles after the first.
//  Backpressure: ready_i=0 with 2 words held -> no fetch; with 1 held + 1 in flight -> no fetch.
//  level_o = wrptr_i - pop_ptr (mod 2**(AW+1)); pop_ptr += 1 on every pop.
//  Wrap-around: all pointers modulo 2**(AW+1); address = low AW bits; 2**AW-1 -> 0 with no stall.
//  Empty: avail=0 -> no fetch; buffer drains normally; valid_o drops after the last pop.
//  flush_i (priority over fetch, capture and pop): at that edge fetch_ptr, relptr, pop_ptr := wrptr_i;
//   buf_count, inflight := 0; valid_o=0 next cycle; in-flight RAM data is discarded. level_o=0 after.
//  Reset mid-transfer: all state cleared immediately; in-flight word is lost; writer must reset together.
//  Precondition (not checked in RTL): wrptr_i - relptr_o <= 2**AW; the bench asserts it.
// STRUCTURE
//  fifo_pkg: ptr_width = ADDRESS_WIDTH+1, FIFO_DEPTH = 2**ADDRESS_WIDTH, shared pointer-difference function
//   (also used by the write-side controller for full/level).
//  Sub-module fifo_out_skid: 2-entry output buffer (push, pop, count, head data, valid), DW-parameterised.
//  Top: pointer registers, fetch/inflight logic, relptr and level arithmetic.
// TESTING (AW=3, depth 8, paired with ram_dual and a model writer)
//  1 Reset: hold rstn=0, toggle inputs -> valid_o=0, data_o=0, ramaddr_o=0, relptr_o=0, level_o=wrptr_i.
//  2 Latency: write 0xA5 at slot 0, wrptr 0->1 in cycle t, ready=1 -> valid_o high in t+2 with 0xA5, relptr_o=1.
//  3 Streaming + wrap: 20 words 0..19 with ready=1 -> in-order 1 word/cycle, addresses wrap 7->0, level_o ends 0.
//  4 Backpressure: 5 words queued, ready=0 for 10 cycles -> data_o held at word0, relptr_o stops at 2, level_o=5;
//    release ready -> words 0..4 back-to-back.
//  5 Flush: 6 words queued, 1 in flight, flush_i 1 cycle -> valid_o=0 next cycle, relptr_o=wrptr_i, level_o=0;
//    next write delivered correctly.
//  6 Random ready/writes, 10k cycles vs scoreboard -> no loss, duplicate or reorder; precondition never violated.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: default geometry and pointer arithmetic helpers.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fifo_pkg;

    localparam int DEF_ADDRESS_WIDTH = 13;
    localparam int DEF_DATA_WIDTH    = 32;

    // Pointers carry one extra wrap bit above the RAM address.
    function automatic int ptr_width(input int address_width);
        return address_width + 1;
    endfunction

    function automatic int fifo_depth(input int address_width);
        return 2 ** address_width;
    endfunction

    // Modular pointer difference. The caller truncates the result to its
    // pointer width, so the low bits give the correct distance across wrap.
    function automatic logic [31:0] ptr_diff(input logic [31:0] a, input logic [31:0] b);
        return a - b;
    endfunction

endpackage

// File: rtl/fifo_out_skid.sv
// Two-entry output buffer for the FIFO read side; head word is presented as the stream data.
// Latency: a pushed word is visible at the head one cycle after the push edge.
// Backpressure: caller must not push when full without a same-cycle pop; head holds until popped.
//
// Ports:
//   clk_i, rstn_i   clock and asynchronous active-low reset
//   flush_i         synchronous discard of both entries (wins over push/pop)
//   push_i, push_data_i   write a word into the buffer
//   pop_i           remove the head word (only when count_o != 0)
//   count_o         number of held words (0..2)
//   data_o, valid_o head word and its valid flag
module fifo_out_skid #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  flush_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_i,
    output logic [1:0]            count_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o
);

    logic [DATA_WIDTH-1:0] head_q;
    logic [DATA_WIDTH-1:0] tail_q;
    logic [1:0]            count_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else if (flush_i) begin
            count_q <= 2'd0;
        end else begin
            case ({push_i, pop_i})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        head_q <= push_data_i;
                    end else begin
                        tail_q <= push_data_i;
                    end
                    count_q <= count_q + 2'd1;
                end
                2'b01: begin
                    // Head only changes when a second word is waiting behind it.
                    if (count_q == 2'd2) begin
                        head_q <= tail_q;
                    end
                    count_q <= count_q - 2'd1;
                end
                2'b11: begin
                    // Count unchanged, head advances.
                    if (count_q == 2'd1) begin
                        head_q <= push_data_i;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= push_data_i;
                    end
                end
                default: ;
            endcase
        end
    end

    assign count_o = count_q;
    assign data_o  = head_q;
    assign valid_o = (count_q != 2'd0);

endmodule

// File: rtl/fifo_read_ctrl.sv
// Read-side FIFO controller: fetches from the dual-port RAM and presents a show-ahead valid/ready stream.
// Latency: write pointer advance in cycle t (empty FIFO) -> valid in t+2; 1 word/cycle sustained afterwards.
// Backpressure: fetches stop when held + in-flight words would exceed the 2-entry output buffer.
//
// Ports:
//   fiford_clk_i / fiford_rstn_i   clock (shared with RAM) and async active-low reset
//   fiford_wrptr_i                 writer's next-write pointer (AW+1 bits, same clock)
//   fiford_flush_i                 synchronous discard of all unread entries
//   fiford_ramaddr_o / fiford_ramdata_i   RAM read address and registered-address read data
//   fiford_relptr_o                slots below this pointer may be overwritten by the writer
//   fiford_data_o / fiford_valid_o / fiford_ready_i   output stream
//   fiford_level_o                 entries written but not yet popped
module fifo_read_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH
) (
    input  logic                     fiford_clk_i,
    input  logic                     fiford_rstn_i,
    input  logic [ADDRESS_WIDTH:0]   fiford_wrptr_i,
    input  logic                     fiford_flush_i,
    output logic [ADDRESS_WIDTH-1:0] fiford_ramaddr_o,
    input  logic [DATA_WIDTH-1:0]    fiford_ramdata_i,
    output logic [ADDRESS_WIDTH:0]   fiford_relptr_o,
    output logic [DATA_WIDTH-1:0]    fiford_data_o,
    output logic                     fiford_valid_o,
    input  logic                     fiford_ready_i,
    output logic [ADDRESS_WIDTH:0]   fiford_level_o
);

    localparam int            PW      = ptr_width(ADDRESS_WIDTH);
    localparam logic [PW-1:0] PTR_ONE = 1;

    logic [PW-1:0] fetch_ptr;
    logic [PW-1:0] rel_ptr;
    logic [PW-1:0] pop_ptr;
    logic          inflight;

    logic [1:0]    buf_count;
    logic [1:0]    occ;
    logic          avail;
    logic          pop;
    logic          fetch;
    logic          capture;

    assign avail = (fiford_wrptr_i != fetch_ptr);
    assign pop   = fiford_valid_o & fiford_ready_i;
    assign occ   = buf_count + {1'b0, inflight};

    // A pop this cycle frees a slot for the word fetched now, which lands
    // two edges later; pop implies occ >= 1 so the subtraction cannot wrap.
    assign fetch   = avail & ((occ - {1'b0, pop}) < 2'd2) & ~fiford_flush_i;

    // The RAM word addressed last cycle is on fiford_ramdata_i now.
    assign capture = inflight & ~fiford_flush_i;

    assign fiford_ramaddr_o = fetch_ptr[ADDRESS_WIDTH-1:0];

    always_ff @(posedge fiford_clk_i or negedge fiford_rstn_i) begin
        if (!fiford_rstn_i) begin
            fetch_ptr <= '0;
            rel_ptr   <= '0;
            pop_ptr   <= '0;
            inflight  <= 1'b0;
        end else if (fiford_flush_i) begin
            fetch_ptr <= fiford_wrptr_i;
            rel_ptr   <= fiford_wrptr_i;
            pop_ptr   <= fiford_wrptr_i;
            inflight  <= 1'b0;
        end else begin
            if (fetch) begin
                fetch_ptr <= fetch_ptr + PTR_ONE;
            end
            inflight <= fetch;
            // Release a slot only once its word sits in the output buffer,
            // so a writer overwrite on the same edge cannot corrupt it.
            if (capture) begin
                rel_ptr <= rel_ptr + PTR_ONE;
            end
            if (pop) begin
                pop_ptr <= pop_ptr + PTR_ONE;
            end
        end
    end

    fifo_out_skid #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out_skid (
        .clk_i       (fiford_clk_i),
        .rstn_i      (fiford_rstn_i),
        .flush_i     (fiford_flush_i),
        .push_i      (capture),
        .push_data_i (fiford_ramdata_i),
        .pop_i       (pop),
        .count_o     (buf_count),
        .data_o      (fiford_data_o),
        .valid_o     (fiford_valid_o)
    );

    assign fiford_relptr_o = rel_ptr;
    assign fiford_level_o  = PW'(ptr_diff(32'(fiford_wrptr_i), 32'(pop_ptr)));

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Bench for fifo_read_ctrl with a registered-address RAM model and a model writer.
// Latency: n/a.
// Backpressure: n/a.
module tb_fifo_read_ctrl;

    localparam int AW    = 3;
    localparam int DW    = 32;
    localparam int PW    = AW + 1;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rstn;
    logic [PW-1:0] wrptr;
    logic          flush;
    logic [AW-1:0] ramaddr;
    logic [DW-1:0] ramdata;
    logic [PW-1:0] relptr;
    logic [DW-1:0] data;
    logic          valid;
    logic          ready;
    logic [PW-1:0] level;

    always #5 clk = ~clk;

    // RAM model: read address registered on the clock, data read from the registered address.
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] ram_addr_q;
    always_ff @(posedge clk) ram_addr_q <= ramaddr;
    assign ramdata = mem[ram_addr_q];

    fifo_read_ctrl #(
        .ADDRESS_WIDTH (AW),
        .DATA_WIDTH    (DW)
    ) dut (
        .fiford_clk_i     (clk),
        .fiford_rstn_i    (rstn),
        .fiford_wrptr_i   (wrptr),
        .fiford_flush_i   (flush),
        .fiford_ramaddr_o (ramaddr),
        .fiford_ramdata_i (ramdata),
        .fiford_relptr_o  (relptr),
        .fiford_data_o    (data),
        .fiford_valid_o   (valid),
        .fiford_ready_i   (ready),
        .fiford_level_o   (level)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Model writer: store the word, then advance the pointer in the same cycle.
    task automatic wr(input logic [DW-1:0] v);
        mem[wrptr[AW-1:0]] = v;
        wrptr = wrptr + 1'b1;
    endtask

    function automatic bit space();
        logic [PW-1:0] d;
        d = wrptr - relptr;
        return d < PW'(DEPTH);
    endfunction

    typedef struct {
        logic [PW-1:0] wrptr;
        logic          ready;
        logic          flush;
        logic [PW-1:0] exp_level;
    } rst_vec_t;

    rst_vec_t rtab [6];

    logic [DW-1:0] exp_q [$];
    logic [PW-1:0] m_pop;
    logic [PW-1:0] held;
    logic [PW-1:0] base;
    logic [AW-1:0] prev_addr;
    logic [DW-1:0] v;
    bit            saw_wrap;
    int            nw, nr, first, last, thr;

    initial begin
        rtab[0] = '{4'd0,  1'b0, 1'b0, 4'd0};
        rtab[1] = '{4'd5,  1'b1, 1'b0, 4'd5};
        rtab[2] = '{4'd15, 1'b1, 1'b1, 4'd15};
        rtab[3] = '{4'd8,  1'b0, 1'b1, 4'd8};
        rtab[4] = '{4'd3,  1'b1, 1'b1, 4'd3};
        rtab[5] = '{4'd12, 1'b0, 0,    4'd12};

        for (int i = 0; i < DEPTH; i++) mem[i] = 32'hDEAD_0000 + 32'(i);
        rstn  = 1'b0;
        wrptr = '0;
        flush = 1'b0;
        ready = 1'b0;

        // ---- Reset: outputs held at reset values while inputs toggle ----
        for (int i = 0; i < 6; i++) begin
            cyc();
            wrptr = rtab[i].wrptr;
            ready = rtab[i].ready;
            flush = rtab[i].flush;
            smp();
            chk("rst_valid",   32'(valid),   32'd0);
            chk("rst_data",    data,         32'd0);
            chk("rst_ramaddr", 32'(ramaddr), 32'd0);
            chk("rst_relptr",  32'(relptr),  32'd0);
            chk("rst_level",   32'(level),   32'(rtab[i].exp_level));
        end
        cyc();
        wrptr = '0;
        flush = 1'b0;
        ready = 1'b0;
        cyc();
        rstn = 1'b1;

        // ---- Latency: one word, valid two cycles after the pointer moves ----
        cyc();
        wr(32'hA5);
        ready = 1'b1;
        smp();
        chk("lat_t0_valid",   32'(valid),   32'd0);
        chk("lat_t0_ramaddr", 32'(ramaddr), 32'd0);
        cyc();
        smp();
        chk("lat_t1_valid",  32'(valid),  32'd0);
        chk("lat_t1_relptr", 32'(relptr), 32'd0);
        cyc();
        smp();
        chk("lat_t2_valid",  32'(valid),  32'd1);
        chk("lat_t2_data",   data,        32'hA5);
        chk("lat_t2_relptr", 32'(relptr), 32'd1);
        chk("lat_t2_level",  32'(level),  32'd1);
        cyc();
        smp();
        chk("lat_t3_valid", 32'(valid), 32'd0);
        chk("lat_t3_level", 32'(level), 32'd0);

        // ---- Streaming with address wrap ----
        nw = 0; nr = 0; first = -1; last = -1;
        saw_wrap  = 1'b0;
        prev_addr = ramaddr;
        for (int c = 0; c < 60 && nr < 20; c++) begin
            cyc();
            ready = 1'b1;
            if (nw < 20 && space()) begin
                wr(32'(nw));
                nw++;
            end
            smp();
            if (prev_addr == AW'(DEPTH - 1) && ramaddr == '0) saw_wrap = 1'b1;
            prev_addr = ramaddr;
            if (valid && ready) begin
                chk("stream_data", data, 32'(nr));
                if (nr == 0) first = c;
                last = c;
                nr++;
            end
        end
        chk("stream_count", 32'(nr), 32'd20);
        chk("stream_gap",   32'(last - first), 32'd19);
        chk("stream_wrap",  32'(saw_wrap), 32'd1);
        cyc();
        smp();
        chk("stream_level", 32'(level), 32'd0);

        // ---- Backpressure: 5 queued, consumer stalled ----
        base  = wrptr;
        ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            wr(32'h400 + 32'(i));
            smp();
        end
        for (int i = 0; i < 10; i++) begin
            cyc();
            smp();
            chk("bp_hold_data", data, 32'h400);
        end
        chk("bp_valid",  32'(valid),  32'd1);
        chk("bp_relptr", 32'(relptr), 32'(PW'(base + 4'd2)));
        chk("bp_level",  32'(level),  32'd5);
        nr = 0; first = -1; last = -1;
        for (int c = 0; c < 12 && nr < 5; c++) begin
            cyc();
            ready = 1'b1;
            smp();
            if (valid && ready) begin
                chk("bp_data", data, 32'h400 + 32'(nr));
                if (nr == 0) first = c;
                last = c;
                nr++;
            end
        end
        chk("bp_count", 32'(nr), 32'd5);
        chk("bp_gap",   32'(last - first), 32'd4);

        // ---- Flush with one word in flight ----
        cyc();
        ready = 1'b0;
        smp();
        for (int i = 0; i < 7; i++) begin
            cyc();
            wr(32'h500 + 32'(i));
            smp();
        end
        for (int i = 0; i < 3; i++) begin
            cyc();
            smp();
        end
        cyc();
        ready = 1'b1;
        smp();
        chk("fl_pre_data", data, 32'h500);
        cyc();
        ready = 1'b0;
        flush = 1'b1;
        smp();
        chk("fl_pre_level", 32'(level), 32'd6);
        cyc();
        flush = 1'b0;
        smp();
        chk("fl_valid",  32'(valid),  32'd0);
        chk("fl_relptr", 32'(relptr), 32'(wrptr));
        chk("fl_level",  32'(level),  32'd0);
        cyc();
        smp();
        chk("fl_discard_valid", 32'(valid), 32'd0);
        cyc();
        wr(32'h5A);
        ready = 1'b1;
        smp();
        chk("fl_new_t0", 32'(valid), 32'd0);
        cyc();
        smp();
        chk("fl_new_t1", 32'(valid), 32'd0);
        cyc();
        smp();
        chk("fl_new_valid", 32'(valid), 32'd1);
        chk("fl_new_data",  data,       32'h5A);
        cyc();
        smp();
        chk("fl_new_empty", 32'(valid), 32'd0);
        chk("fl_new_level", 32'(level), 32'd0);

        // ---- Random traffic against a queue model ----
        exp_q.delete();
        m_pop = wrptr;
        thr   = 5;
        for (int c = 0; c < 10000; c++) begin
            cyc();
            if (c % 500 == 0) thr = $urandom_range(1, 10);
            ready = ($urandom_range(0, 9) < thr);
            flush = ($urandom_range(0, 299) == 0);
            if (space() && $urandom_range(0, 1) == 1) begin
                v = $urandom;
                wr(v);
                exp_q.push_back(v);
            end
            smp();
            held = relptr - m_pop;
            chk("rnd_precond", 32'((wrptr - relptr) <= PW'(DEPTH)), 32'd1);
            chk("rnd_held_max", 32'(held <= 4'd2), 32'd1);
            chk("rnd_valid",    32'(valid), 32'(held != '0));
            chk("rnd_level",    32'(level), 32'(PW'(wrptr - m_pop)));
            if (flush) begin
                exp_q.delete();
                m_pop = wrptr;
            end else if (valid && ready) begin
                if (exp_q.size() == 0) begin
                    chk("rnd_extra_word", 32'(valid), 32'd0);
                end else begin
                    chk("rnd_data", data, exp_q.pop_front());
                    m_pop = m_pop + 1'b1;
                end
            end
        end
        cyc();
        flush = 1'b0;
        ready = 1'b1;
        smp();
        for (int c = 0; c < 30 && exp_q.size() != 0; c++) begin
            if (valid) begin
                chk("drain_data", data, exp_q.pop_front());
            end
            cyc();
            smp();
        end
        chk("drain_left", 32'(exp_q.size()), 32'd0);
        cyc();
        smp();
        chk("drain_valid", 32'(valid), 32'd0);
        chk("drain_level", 32'(level), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
